apb2axi_directory: RTL and testbench
====================================

APB2AXI_DIRECTORY -- requirements
Module: apb2axi_directory

Interface
REQ-001 SHALL have parameter TAG_W, default TAG_W from apb2axi_pkg, meaning tag width.
REQ-002 SHALL have parameter NUM_TAGS, default 2**TAG_W, meaning number of directory entries.
REQ-003 SHALL have pclk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have presetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have alloc_valid  in  1  allocation request from gateway.
REQ-006 SHALL have alloc_entry  in  directory_entry_t  request fields (addr/len/size/is_write/tag).
REQ-007 SHALL have alloc_ready  out  1  at least one FREE entry.
REQ-008 SHALL have alloc_tag  out  TAG_W  tag granted on an alloc handshake.
REQ-009 SHALL have cpl_valid  in  1  AXI completion.
REQ-010 SHALL have cpl_tag/cpl_is_write/cpl_error/cpl_resp/cpl_num_beats  in  TAG_W/1/1/2/8  completion fields.
REQ-011 SHALL have cpl_ready  out  1  completion accepted.
REQ-012 SHALL have cons_valid  in  1, cons_tag  in  TAG_W  APB consume of a completed tag.
REQ-013 SHALL have req_valid  out  1, req_entry  out  directory_entry_t, req_ready  in  1  issue stream to the AXI-side request path.
REQ-014 SHALL have occupancy  out  TAG_W+1  count of non-FREE entries.
REQ-015 SHALL have proto_err  out  1  one-cycle pulse on an illegal completion or consume.

Function
REQ-016 SHALL hold per-entry state FREE, ALLOCATED, ISSUED or COMPLETE, plus stored entry, error, resp and num_beats.
REQ-017 SHALL drive alloc_ready combinationally as OR of FREE entries, using registered state only.
REQ-018 SHALL drive alloc_tag as the lowest-index FREE entry (priority encode); value is don't-care when alloc_ready=0.
REQ-019 On alloc_valid&&alloc_ready SHALL store alloc_entry with tag overwritten by alloc_tag, set ALLOCATED and push the tag into the issue FIFO, all visible next cycle.
REQ-020 When alloc_valid&&!alloc_ready (full), the request SHALL be dropped with no state change; the upstream holds the request.
REQ-021 SHALL assert req_valid whenever the issue FIFO is non-empty, with req_entry = stored entry of the FIFO head tag (allocation order, FIFO).
REQ-022 On req_valid&&req_ready SHALL pop the head and set that entry ISSUED; req_entry SHALL stay stable while req_valid&&!req_ready.
REQ-023 SHALL tie cpl_ready to 1.
REQ-024 On cpl_valid, if state[cpl_tag]==ISSUED, SHALL store error/resp/num_beats and set COMPLETE; otherwise SHALL ignore the completion and pulse proto_err.
REQ-025 On cons_valid, if state[cons_tag]==COMPLETE, SHALL set FREE; otherwise SHALL ignore the consume and pulse proto_err.
REQ-026 A tag freed by consume SHALL NOT be allocatable in the same cycle; it becomes available the next cycle.
REQ-027 On cpl and cons for the same tag in one cycle, the consume SHALL see pre-cycle state (ISSUED), so it is illegal and proto_err pulses, while the completion is applied.
REQ-028 Alloc, issue, completion and consume on different tags in one cycle SHALL all take effect.
REQ-029 occupancy SHALL be registered, +1 per alloc, -1 per legal consume, net on coincidence, and range 0..NUM_TAGS.
REQ-030 The issue FIFO depth SHALL be NUM_TAGS; it cannot overflow, and push/pop wrap modulo NUM_TAGS.

Reset
REQ-031 When presetn=0 at a pclk edge, SHALL set all entries FREE, empty the FIFO, and set occupancy=0 and proto_err=0; stored payloads are don't-care.
REQ-032 During reset, outputs SHALL be alloc_ready=1, alloc_tag=0, req_valid=0 and cpl_ready=1; reset mid-transaction discards all in-flight tags.

Structure
REQ-033 SHALL keep directory_entry_t, dir_state_e (FREE/ALLOCATED/ISSUED/COMPLETE), TAG_W and NUM_TAGS in apb2axi_pkg.
REQ-034 SHALL implement the issue-order queue as sub-module apb2axi_tag_fifo (TAG_W-wide, NUM_TAGS deep, synchronous active-low reset).

Verification (TAG_W=2)
REQ-035 Reset, then 4 allocs with addr 0x100..0x400 -> alloc_tag 0,1,2,3; alloc_ready=0 after the 4th; occupancy=4.
REQ-036 req_ready=1 after REQ-035 -> req_entry.addr 0x100,0x200,0x300,0x400 on consecutive cycles with req_entry.tag=0..3; req_valid=0 afterwards.
REQ-037 cpl tag 2 (resp=2'b10, error=1, beats=4), then cons tag 2 -> tag 2 FREE; next alloc gets tag 2; occupancy 4->3->4.
REQ-038 cons tag 1 while ISSUED, and cpl tag 3 when FREE -> proto_err pulses one cycle each with no state change.
REQ-039 Full directory, cons of completed tag 0 with alloc_valid in the same cycle -> alloc_ready=0 that cycle; tag 0 granted the next cycle.
REQ-040 presetn=0 with 3 tags ISSUED and req_valid=1 -> next cycle req_valid=0, occupancy=0, alloc_tag=0.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared types and sizing for the APB-to-AXI tag directory.
// The directory entry, per-tag state and completion record live here.
package apb2axi_pkg;

    localparam int TAG_W    = 2;
    localparam int NUM_TAGS = 2 ** TAG_W;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        ALLOCATED = 2'd1,
        ISSUED    = 2'd2,
        COMPLETE  = 2'd3
    } dir_state_e;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic             is_write;
        logic [TAG_W-1:0] tag;
    } directory_entry_t;

    typedef struct packed {
        logic       error;
        logic [1:0] resp;
        logic [7:0] num_beats;
    } cpl_info_t;

endpackage

// File: rtl/apb2axi_directory_if.sv
// Gateway-facing bundle of the directory: alloc, issue, completion and consume.
// master = gateway/AXI side driving requests, slave = the directory itself.
interface apb2axi_directory_if
    import apb2axi_pkg::*;
#(
    parameter int TAG_W = apb2axi_pkg::TAG_W
) ();

    logic             alloc_valid;
    directory_entry_t alloc_entry;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic             cpl_is_write;
    logic             cpl_error;
    logic [1:0]       cpl_resp;
    logic [7:0]       cpl_num_beats;
    logic             cpl_ready;

    logic             cons_valid;
    logic [TAG_W-1:0] cons_tag;

    logic             req_valid;
    directory_entry_t req_entry;
    logic             req_ready;

    logic [TAG_W:0]   occupancy;
    logic             proto_err;

    modport master (
        output alloc_valid, alloc_entry,
        input  alloc_ready, alloc_tag,
        output cpl_valid, cpl_tag, cpl_is_write, cpl_error, cpl_resp, cpl_num_beats,
        input  cpl_ready,
        output cons_valid, cons_tag,
        input  req_valid, req_entry,
        output req_ready,
        input  occupancy, proto_err
    );

    modport slave (
        input  alloc_valid, alloc_entry,
        output alloc_ready, alloc_tag,
        input  cpl_valid, cpl_tag, cpl_is_write, cpl_error, cpl_resp, cpl_num_beats,
        output cpl_ready,
        input  cons_valid, cons_tag,
        output req_valid, req_entry,
        input  req_ready,
        output occupancy, proto_err
    );

endinterface

// File: rtl/apb2axi_tag_fifo.sv
// Issue-order queue of tags. Depth equals the tag count, so it can never
// overflow while the directory only pushes tags it has just allocated.
module apb2axi_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 2 ** TAG_W
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             valid
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] wr_q;
    logic [TAG_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + TAG_W'(1);
    endfunction

    assign valid  = (count_q != '0);
    assign pop_ok = pop && valid;
    assign head   = mem_q[rd_q];

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push)   wr_q <= wrap_inc(wr_q);
            if (pop_ok) rd_q <= wrap_inc(rd_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written.
    always_ff @(posedge pclk) begin
        if (push) mem_q[wr_q] <= push_tag;
    end

endmodule

// File: rtl/apb2axi_directory.sv
// Tag directory between the APB gateway and the AXI request path: allocates
// tags, issues them in order, records completions and frees them on consume.
module apb2axi_directory
    import apb2axi_pkg::*;
#(
    parameter int TAG_W    = apb2axi_pkg::TAG_W,
    parameter int NUM_TAGS = 2 ** TAG_W
) (
    input logic               pclk,
    input logic               presetn,
    apb2axi_directory_if.slave dir
);

    localparam int OCC_W = TAG_W + 1;

    dir_state_e                 state_q [NUM_TAGS];
    dir_state_e                 state_d [NUM_TAGS];
    directory_entry_t           entry_q [NUM_TAGS];
    cpl_info_t [NUM_TAGS-1:0]   info_q;
    logic [OCC_W-1:0]           occ_q;
    logic [OCC_W-1:0]           occ_d;
    logic                       proto_err_q;
    logic                       proto_err_d;

    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag;
    logic [TAG_W-1:0]           head_tag;
    logic                       fifo_valid;
    logic                       do_alloc;
    logic                       do_issue;
    logic                       cpl_ok;
    logic                       cons_ok;
    directory_entry_t           alloc_rec;
    logic                       unused_cpl;

    // Legality is judged on pre-cycle state, so a same-cycle cpl+cons on one tag
    // rejects the consume and a just-freed tag is not re-granted until next cycle.
    assign do_alloc = dir.alloc_valid && alloc_ready;
    assign do_issue = fifo_valid && dir.req_ready;
    assign cpl_ok   = dir.cpl_valid  && (state_q[dir.cpl_tag]  == ISSUED);
    assign cons_ok  = dir.cons_valid && (state_q[dir.cons_tag] == COMPLETE);

    apb2axi_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (NUM_TAGS)
    ) u_tag_fifo (
        .pclk     (pclk),
        .presetn  (presetn),
        .push     (do_alloc),
        .push_tag (alloc_tag),
        .pop      (do_issue),
        .head     (head_tag),
        .valid    (fifo_valid)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_TAGS; i++) state_q[i] <= FREE;
            occ_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_alloc) entry_q[alloc_tag] <= alloc_rec;
        if (cpl_ok)   info_q[dir.cpl_tag] <= '{error:     dir.cpl_error,
                                               resp:      dir.cpl_resp,
                                               num_beats: dir.cpl_num_beats};
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (do_alloc) state_d[alloc_tag]    = ALLOCATED;
        if (do_issue) state_d[head_tag]     = ISSUED;
        if (cpl_ok)   state_d[dir.cpl_tag]  = COMPLETE;
        if (cons_ok)  state_d[dir.cons_tag] = FREE;
        occ_d       = occ_q + OCC_W'(do_alloc) - OCC_W'(cons_ok);
        proto_err_d = (dir.cpl_valid && !cpl_ok) || (dir.cons_valid && !cons_ok);
    end

    // Lowest-index FREE entry wins the grant.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                alloc_ready = 1'b1;
                alloc_tag   = TAG_W'(i);
            end
        end
        alloc_rec     = dir.alloc_entry;
        alloc_rec.tag = alloc_tag;
    end

    assign dir.alloc_ready = alloc_ready;
    assign dir.alloc_tag   = alloc_tag;
    assign dir.cpl_ready   = 1'b1;
    assign dir.req_valid   = fifo_valid;
    assign dir.req_entry   = entry_q[head_tag];
    assign dir.occupancy   = occ_q;
    assign dir.proto_err   = proto_err_q;

    assign unused_cpl = ^{info_q, dir.cpl_is_write};

endmodule

// File: tb/tb_apb2axi_directory.sv
// Directed bench for apb2axi_directory (TAG_W=2): allocation, in-order issue,
// completion/consume legality, same-cycle interactions and mid-flight reset.
module tb_apb2axi_directory;
    import apb2axi_pkg::*;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    apb2axi_directory_if dif ();

    apb2axi_directory dut (
        .pclk    (pclk),
        .presetn (presetn),
        .dir     (dif.slave)
    );

    always #5 pclk = ~pclk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic idle();
        dif.alloc_valid   = 1'b0;
        dif.alloc_entry   = '0;
        dif.cpl_valid     = 1'b0;
        dif.cpl_tag       = '0;
        dif.cpl_is_write  = 1'b0;
        dif.cpl_error     = 1'b0;
        dif.cpl_resp      = 2'b00;
        dif.cpl_num_beats = 8'd0;
        dif.cons_valid    = 1'b0;
        dif.cons_tag      = '0;
        dif.req_ready     = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] addr);
        dif.alloc_valid = 1'b1;
        dif.alloc_entry = '{addr: addr, len: 8'd3, size: 3'd2, is_write: 1'b1, tag: 2'd3};
    endtask

    task automatic set_cpl(input logic [1:0] tag, input logic [1:0] resp, input logic err, input logic [7:0] beats);
        dif.cpl_valid     = 1'b1;
        dif.cpl_tag       = tag;
        dif.cpl_resp      = resp;
        dif.cpl_error     = err;
        dif.cpl_num_beats = beats;
    endtask

    task automatic test_reset();
        idle();
        presetn = 1'b0;
        tick();
        tick();
        checks++; if (dif.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b want 1", dif.alloc_ready); end
        checks++; if (dif.alloc_tag !== 2'd0) begin errors++; $display("FAIL reset_alloc_tag: got %0d want 0", dif.alloc_tag); end
        checks++; if (dif.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", dif.req_valid); end
        checks++; if (dif.cpl_ready !== 1'b1) begin errors++; $display("FAIL reset_cpl_ready: got %b want 1", dif.cpl_ready); end
        checks++; if (dif.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", dif.occupancy); end
        checks++; if (dif.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", dif.proto_err); end
        presetn = 1'b1;
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'((i + 1) * 'h100));
            checks++; if (dif.alloc_ready !== 1'b1) begin errors++; $display("FAIL alloc_ready_%0d: got %b want 1", i, dif.alloc_ready); end
            checks++; if (dif.alloc_tag !== 2'(i)) begin errors++; $display("FAIL alloc_tag_%0d: got %0d want %0d", i, dif.alloc_tag, i); end
            tick();
            checks++; if (dif.req_entry.addr !== 32'h100) begin errors++; $display("FAIL req_head_hold_%0d: got %h want 100", i, dif.req_entry.addr); end
        end
        checks++; if (dif.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %b want 0", dif.alloc_ready); end
        checks++; if (dif.occupancy !== 3'd4) begin errors++; $display("FAIL full_occupancy: got %0d want 4", dif.occupancy); end
        // A request arriving while full is dropped.
        set_alloc(32'h0DEAD000);
        tick();
        dif.alloc_valid = 1'b0;
        checks++; if (dif.occupancy !== 3'd4) begin errors++; $display("FAIL drop_occupancy: got %0d want 4", dif.occupancy); end
        checks++; if (dif.req_valid !== 1'b1) begin errors++; $display("FAIL drop_req_valid: got %b want 1", dif.req_valid); end
    endtask

    task automatic test_issue();
        dif.req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dif.req_valid !== 1'b1) begin errors++; $display("FAIL issue_valid_%0d: got %b want 1", i, dif.req_valid); end
            checks++; if (dif.req_entry.addr !== 32'((i + 1) * 'h100)) begin errors++; $display("FAIL issue_addr_%0d: got %h want %h", i, dif.req_entry.addr, (i + 1) * 'h100); end
            checks++; if (dif.req_entry.tag !== 2'(i)) begin errors++; $display("FAIL issue_tag_%0d: got %0d want %0d", i, dif.req_entry.tag, i); end
            tick();
        end
        dif.req_ready = 1'b0;
        checks++; if (dif.req_valid !== 1'b0) begin errors++; $display("FAIL issue_drained: got %b want 0", dif.req_valid); end
    endtask

    task automatic test_complete_consume();
        set_cpl(2'd2, 2'b10, 1'b1, 8'd4);
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b0) begin errors++; $display("FAIL cpl2_proto_err: got %b want 0", dif.proto_err); end
        checks++; if (dif.occupancy !== 3'd4) begin errors++; $display("FAIL cpl2_occupancy: got %0d want 4", dif.occupancy); end
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd2;
        tick();
        idle();
        checks++; if (dif.occupancy !== 3'd3) begin errors++; $display("FAIL cons2_occupancy: got %0d want 3", dif.occupancy); end
        checks++; if (dif.alloc_tag !== 2'd2 || dif.alloc_ready !== 1'b1) begin errors++; $display("FAIL cons2_alloc_tag: got %0d/%b want 2/1", dif.alloc_tag, dif.alloc_ready); end
        set_alloc(32'h500);
        tick();
        idle();
        checks++; if (dif.occupancy !== 3'd4) begin errors++; $display("FAIL realloc_occupancy: got %0d want 4", dif.occupancy); end
        checks++; if (dif.req_entry.addr !== 32'h500 || dif.req_entry.tag !== 2'd2) begin errors++; $display("FAIL realloc_req: got %h/%0d want 500/2", dif.req_entry.addr, dif.req_entry.tag); end
        dif.req_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_proto_err();
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd1;
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b1) begin errors++; $display("FAIL cons_issued_err: got %b want 1", dif.proto_err); end
        checks++; if (dif.occupancy !== 3'd4) begin errors++; $display("FAIL cons_issued_occ: got %0d want 4", dif.occupancy); end
        tick();
        checks++; if (dif.proto_err !== 1'b0) begin errors++; $display("FAIL cons_issued_pulse: got %b want 0", dif.proto_err); end
        set_cpl(2'd3, 2'b00, 1'b0, 8'd1);
        tick();
        idle();
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd3;
        tick();
        idle();
        set_cpl(2'd3, 2'b00, 1'b0, 8'd1);
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b1) begin errors++; $display("FAIL cpl_free_err: got %b want 1", dif.proto_err); end
        tick();
        checks++; if (dif.proto_err !== 1'b0) begin errors++; $display("FAIL cpl_free_pulse: got %b want 0", dif.proto_err); end
        checks++; if (dif.occupancy !== 3'd3 || dif.alloc_tag !== 2'd3) begin errors++; $display("FAIL cpl_free_state: got occ %0d tag %0d want 3/3", dif.occupancy, dif.alloc_tag); end
    endtask

    task automatic test_same_tag();
        set_cpl(2'd1, 2'b00, 1'b0, 8'd2);
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd1;
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b1) begin errors++; $display("FAIL same_tag_err: got %b want 1", dif.proto_err); end
        checks++; if (dif.occupancy !== 3'd3) begin errors++; $display("FAIL same_tag_occ: got %0d want 3", dif.occupancy); end
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd1;
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b0 || dif.occupancy !== 3'd2) begin errors++; $display("FAIL same_tag_cons: got err %b occ %0d want 0/2", dif.proto_err, dif.occupancy); end
        checks++; if (dif.alloc_tag !== 2'd1) begin errors++; $display("FAIL same_tag_alloc_tag: got %0d want 1", dif.alloc_tag); end
    endtask

    task automatic test_concurrent();
        set_alloc(32'h600);
        tick();
        idle();
        set_cpl(2'd2, 2'b01, 1'b0, 8'd8);
        tick();
        idle();
        set_alloc(32'h700);
        dif.req_ready  = 1'b1;
        set_cpl(2'd0, 2'b00, 1'b0, 8'd1);
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd2;
        checks++; if (dif.alloc_tag !== 2'd3 || dif.req_entry.addr !== 32'h600 || dif.req_entry.tag !== 2'd1) begin errors++; $display("FAIL conc_pre: got tag %0d head %h/%0d want 3 600/1", dif.alloc_tag, dif.req_entry.addr, dif.req_entry.tag); end
        tick();
        idle();
        checks++; if (dif.occupancy !== 3'd3 || dif.proto_err !== 1'b0) begin errors++; $display("FAIL conc_occ: got occ %0d err %b want 3/0", dif.occupancy, dif.proto_err); end
        checks++; if (dif.alloc_ready !== 1'b1 || dif.alloc_tag !== 2'd2) begin errors++; $display("FAIL conc_alloc: got %b/%0d want 1/2", dif.alloc_ready, dif.alloc_tag); end
        checks++; if (dif.req_valid !== 1'b1 || dif.req_entry.addr !== 32'h700 || dif.req_entry.tag !== 2'd3) begin errors++; $display("FAIL conc_head: got %b %h/%0d want 1 700/3", dif.req_valid, dif.req_entry.addr, dif.req_entry.tag); end
    endtask

    task automatic test_free_same_cycle();
        set_alloc(32'h800);
        tick();
        checks++; if (dif.alloc_ready !== 1'b0 || dif.occupancy !== 3'd4) begin errors++; $display("FAIL fsc_full: got %b occ %0d want 0/4", dif.alloc_ready, dif.occupancy); end
        set_alloc(32'h900);
        dif.cons_valid = 1'b1;
        dif.cons_tag   = 2'd0;
        checks++; if (dif.alloc_ready !== 1'b0) begin errors++; $display("FAIL fsc_same_cycle_ready: got %b want 0", dif.alloc_ready); end
        tick();
        dif.cons_valid = 1'b0;
        checks++; if (dif.alloc_ready !== 1'b1 || dif.alloc_tag !== 2'd0 || dif.occupancy !== 3'd3) begin errors++; $display("FAIL fsc_next_cycle: got %b tag %0d occ %0d want 1/0/3", dif.alloc_ready, dif.alloc_tag, dif.occupancy); end
        tick();
        idle();
        checks++; if (dif.alloc_ready !== 1'b0 || dif.occupancy !== 3'd4) begin errors++; $display("FAIL fsc_regrant: got %b occ %0d want 0/4", dif.alloc_ready, dif.occupancy); end
        checks++; if (dif.req_entry.addr !== 32'h700) begin errors++; $display("FAIL fsc_head: got %h want 700", dif.req_entry.addr); end
    endtask

    task automatic test_reset_midflight();
        dif.req_ready = 1'b1;
        tick();
        tick();
        idle();
        checks++; if (dif.req_valid !== 1'b1 || dif.req_entry.addr !== 32'h900 || dif.req_entry.tag !== 2'd0) begin errors++; $display("FAIL mid_pre: got %b %h/%0d want 1 900/0", dif.req_valid, dif.req_entry.addr, dif.req_entry.tag); end
        presetn = 1'b0;
        tick();
        checks++; if (dif.req_valid !== 1'b0 || dif.occupancy !== 3'd0 || dif.alloc_tag !== 2'd0) begin errors++; $display("FAIL mid_reset: got rv %b occ %0d tag %0d want 0/0/0", dif.req_valid, dif.occupancy, dif.alloc_tag); end
        checks++; if (dif.alloc_ready !== 1'b1 || dif.cpl_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b/%b want 1/1", dif.alloc_ready, dif.cpl_ready); end
        presetn = 1'b1;
        set_cpl(2'd1, 2'b00, 1'b0, 8'd1);
        tick();
        idle();
        checks++; if (dif.proto_err !== 1'b1 || dif.occupancy !== 3'd0) begin errors++; $display("FAIL mid_discarded: got err %b occ %0d want 1/0", dif.proto_err, dif.occupancy); end
    endtask

    initial begin
        idle();
        @(negedge pclk);
        test_reset();
        test_alloc();
        test_issue();
        test_complete_consume();
        test_proto_err();
        test_same_tag();
        test_concurrent();
        test_free_same_cycle();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
